// File: rtl/alarm_bank.sv
// Bank of independently armed alarms driven by an external time-of-day source.
// Each channel has its own IDLE/RINGING/SNOOZED machine with snooze, dismiss and ring timeout.
module alarm_bank #(
    parameter int N_ALARMS   = 4,
    parameter int RING_SECS  = 60,
    parameter int SNOOZE_MIN = 5,
    localparam int CW = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [5:0]          sec_in,
    input  logic [5:0]          min_in,
    input  logic [4:0]          hour_in,
    input  logic [CW-1:0]       sel_alarm,
    input  logic [1:0]          select,
    input  logic                increment,
    input  logic [N_ALARMS-1:0] arm,
    input  logic                snooze,
    input  logic                dismiss,
    output logic [5:0]          sec_out,
    output logic [5:0]          min_out,
    output logic [4:0]          hour_out,
    output logic [N_ALARMS-1:0] ringing,
    output logic                out,
    output logic [CW-1:0]       ring_id
);

    localparam logic [1:0] SELECT_NONE = 2'd0;
    localparam logic [1:0] SELECT_SEC  = 2'd1;
    localparam logic [1:0] SELECT_MIN  = 2'd2;
    localparam logic [1:0] SELECT_HOUR = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RINGING = 2'd1,
        ST_SNOOZED = 2'd2
    } state_t;

    logic                inc_prev_q;
    logic                snz_prev_q;
    logic                dis_prev_q;
    logic [5:0]          sec_prev_q;
    logic [N_ALARMS-1:0] ringing_q;
    logic [N_ALARMS-1:0] ringing_d;
    logic                out_q;

    logic inc_edge;
    logic snz_edge;
    logic dis_edge;
    logic sec_tick;

    assign inc_edge = increment & ~inc_prev_q;
    assign snz_edge = snooze & ~snz_prev_q;
    assign dis_edge = dismiss & ~dis_prev_q;
    assign sec_tick = (sec_in != sec_prev_q);

    // Snooze target, shared by all channels since it only depends on the current time.
    logic [6:0] snz_min_sum;
    logic [5:0] snz_sec_t;
    logic [5:0] snz_min_t;
    logic [4:0] snz_hour_t;

    always_comb begin
        snz_min_sum = {1'b0, min_in} + 7'(SNOOZE_MIN);
        snz_sec_t   = sec_in;
        snz_min_t   = snz_min_sum[5:0];
        snz_hour_t  = hour_in;
        if (snz_min_sum >= 7'd60) begin
            snz_min_t  = 6'(snz_min_sum - 7'd60);
            snz_hour_t = (hour_in >= 5'd23) ? 5'd0 : hour_in + 5'd1;
        end
    end

    logic [N_ALARMS-1:0][5:0] set_sec_all;
    logic [N_ALARMS-1:0][5:0] set_min_all;
    logic [N_ALARMS-1:0][4:0] set_hour_all;

    for (genvar gi = 0; gi < N_ALARMS; gi++) begin : g_ch
        logic [5:0] set_sec_q, set_sec_d;
        logic [5:0] set_min_q, set_min_d;
        logic [4:0] set_hour_q, set_hour_d;
        logic [5:0] snz_sec_q, snz_sec_d;
        logic [5:0] snz_min_q, snz_min_d;
        logic [4:0] snz_hour_q, snz_hour_d;
        state_t     state_q, state_d;
        logic [7:0] cnt_q, cnt_d;
        logic       prev_hit_q, prev_hit_d;
        logic       hit;
        logic       trig;
        logic       edit_en;

        assign edit_en = inc_edge && (select != SELECT_NONE) && (sel_alarm == CW'(gi));

        always_comb begin
            if (state_q == ST_SNOOZED) begin
                hit = (sec_in == snz_sec_q) && (min_in == snz_min_q) && (hour_in == snz_hour_q);
            end else begin
                hit = (sec_in == set_sec_q) && (min_in == set_min_q) && (hour_in == set_hour_q);
            end
        end

        // Only the first cycle of a match counts, so a dismissed alarm stays quiet for the rest of the second.
        assign trig = hit & ~prev_hit_q;

        always_comb begin
            set_sec_d  = set_sec_q;
            set_min_d  = set_min_q;
            set_hour_d = set_hour_q;
            snz_sec_d  = snz_sec_q;
            snz_min_d  = snz_min_q;
            snz_hour_d = snz_hour_q;
            state_d    = state_q;
            cnt_d      = cnt_q;
            prev_hit_d = hit;

            if (edit_en) begin
                case (select)
                    SELECT_SEC:  set_sec_d  = (set_sec_q >= 6'd59) ? 6'd0 : set_sec_q + 6'd1;
                    SELECT_MIN:  set_min_d  = (set_min_q >= 6'd59) ? 6'd0 : set_min_q + 6'd1;
                    SELECT_HOUR: set_hour_d = (set_hour_q >= 5'd23) ? 5'd0 : set_hour_q + 5'd1;
                    default: ;
                endcase
            end

            if (!arm[gi]) begin
                state_d = ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (trig) begin
                            state_d = ST_RINGING;
                            cnt_d   = 8'(RING_SECS);
                        end
                    end
                    ST_RINGING: begin
                        if (dis_edge) begin
                            state_d = ST_IDLE;
                        end else if (snz_edge) begin
                            state_d    = ST_SNOOZED;
                            snz_sec_d  = snz_sec_t;
                            snz_min_d  = snz_min_t;
                            snz_hour_d = snz_hour_t;
                        end else if (sec_tick) begin
                            if (cnt_q <= 8'd1) begin
                                state_d = ST_IDLE;
                                cnt_d   = 8'd0;
                            end else begin
                                cnt_d = cnt_q - 8'd1;
                            end
                        end
                    end
                    ST_SNOOZED: begin
                        if (dis_edge) begin
                            state_d = ST_IDLE;
                        end else if (trig) begin
                            state_d = ST_RINGING;
                            cnt_d   = 8'(RING_SECS);
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                set_sec_q  <= '0;
                set_min_q  <= '0;
                set_hour_q <= '0;
                snz_sec_q  <= '0;
                snz_min_q  <= '0;
                snz_hour_q <= '0;
                state_q    <= ST_IDLE;
                cnt_q      <= '0;
                prev_hit_q <= 1'b1;
            end else begin
                set_sec_q  <= set_sec_d;
                set_min_q  <= set_min_d;
                set_hour_q <= set_hour_d;
                snz_sec_q  <= snz_sec_d;
                snz_min_q  <= snz_min_d;
                snz_hour_q <= snz_hour_d;
                state_q    <= state_d;
                cnt_q      <= cnt_d;
                prev_hit_q <= prev_hit_d;
            end
        end

        assign set_sec_all[gi]  = set_sec_q;
        assign set_min_all[gi]  = set_min_q;
        assign set_hour_all[gi] = set_hour_q;
        assign ringing_d[gi]    = (state_d == ST_RINGING);
    end

    // Button edge detectors start high so a button held through reset is ignored.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inc_prev_q <= 1'b1;
            snz_prev_q <= 1'b1;
            dis_prev_q <= 1'b1;
            sec_prev_q <= '0;
            ringing_q  <= '0;
            out_q      <= 1'b0;
        end else begin
            inc_prev_q <= increment;
            snz_prev_q <= snooze;
            dis_prev_q <= dismiss;
            sec_prev_q <= sec_in;
            ringing_q  <= ringing_d;
            out_q      <= |ringing_d;
        end
    end

    assign ringing = ringing_q;
    assign out     = out_q;

    always_comb begin
        ring_id = '0;
        for (int i = N_ALARMS - 1; i >= 0; i--) begin
            if (ringing_q[i]) begin
                ring_id = CW'(i);
            end
        end
    end

    logic sel_valid;
    assign sel_valid = (int'(sel_alarm) < N_ALARMS);
    assign sec_out   = sel_valid ? set_sec_all[sel_alarm]  : 6'd0;
    assign min_out   = sel_valid ? set_min_all[sel_alarm]  : 6'd0;
    assign hour_out  = sel_valid ? set_hour_all[sel_alarm] : 5'd0;

endmodule

// File: tb/tb_alarm_bank.sv
// Randomised and directed bench for alarm_bank; a time-in-seconds reference model predicts every output.
module tb_alarm_bank;

    localparam int N  = 4;
    localparam int RS = 3;
    localparam int SM = 5;
    localparam int CW = 2;
    localparam int DAY = 86400;

    localparam logic [1:0] SEL_NONE = 2'd0;
    localparam logic [1:0] SEL_SEC  = 2'd1;
    localparam logic [1:0] SEL_MIN  = 2'd2;
    localparam logic [1:0] SEL_HOUR = 2'd3;

    logic          clk;
    logic          reset;
    logic [5:0]    sec_in;
    logic [5:0]    min_in;
    logic [4:0]    hour_in;
    logic [CW-1:0] sel_alarm;
    logic [1:0]    select;
    logic          increment;
    logic [N-1:0]  arm;
    logic          snooze;
    logic          dismiss;
    logic [5:0]    sec_out;
    logic [5:0]    min_out;
    logic [4:0]    hour_out;
    logic [N-1:0]  ringing;
    logic          out;
    logic [CW-1:0] ring_id;

    alarm_bank #(.N_ALARMS(N), .RING_SECS(RS), .SNOOZE_MIN(SM)) dut (
        .clk(clk), .reset(reset), .sec_in(sec_in), .min_in(min_in), .hour_in(hour_in),
        .sel_alarm(sel_alarm), .select(select), .increment(increment), .arm(arm),
        .snooze(snooze), .dismiss(dismiss), .sec_out(sec_out), .min_out(min_out),
        .hour_out(hour_out), .ringing(ringing), .out(out), .ring_id(ring_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: times kept as seconds-of-day; states 0 idle, 1 ringing, 2 snoozed.
    int m_set[N];
    int m_snz[N];
    int m_st[N];
    int m_cnt[N];
    bit m_pm[N];
    bit m_inc_p, m_snz_p, m_dis_p;
    int m_prev_sec;
    int now_s;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_set[i] = 0; m_snz[i] = 0; m_st[i] = 0; m_cnt[i] = 0; m_pm[i] = 1'b1;
        end
        m_inc_p = 1'b1; m_snz_p = 1'b1; m_dis_p = 1'b1;
        m_prev_sec = 0;
    endtask

    function automatic int bump(input int t, input logic [1:0] fld);
        int h, m, s;
        h = t / 3600; m = (t / 60) % 60; s = t % 60;
        case (fld)
            SEL_SEC:  s = (s + 1) % 60;
            SEL_MIN:  m = (m + 1) % 60;
            SEL_HOUR: h = (h + 1) % 24;
            default: ;
        endcase
        return h * 3600 + m * 60 + s;
    endfunction

    task automatic model_step();
        bit inc_e, snz_e, dis_e, tick, hit, trig;
        int now, tgt;
        inc_e = increment && !m_inc_p;
        snz_e = snooze && !m_snz_p;
        dis_e = dismiss && !m_dis_p;
        tick  = (int'(sec_in) != m_prev_sec);
        now   = int'(hour_in) * 3600 + int'(min_in) * 60 + int'(sec_in);
        for (int i = 0; i < N; i++) begin
            tgt  = (m_st[i] == 2) ? m_snz[i] : m_set[i];
            hit  = (now == tgt);
            trig = hit && !m_pm[i];
            if (!arm[i]) begin
                m_st[i] = 0;
            end else if (m_st[i] == 0) begin
                if (trig) begin m_st[i] = 1; m_cnt[i] = RS; end
            end else if (m_st[i] == 1) begin
                if (dis_e) m_st[i] = 0;
                else if (snz_e) begin m_st[i] = 2; m_snz[i] = (now + SM * 60) % DAY; end
                else if (tick) begin
                    m_cnt[i] = m_cnt[i] - 1;
                    if (m_cnt[i] == 0) m_st[i] = 0;
                end
            end else begin
                if (dis_e) m_st[i] = 0;
                else if (trig) begin m_st[i] = 1; m_cnt[i] = RS; end
            end
            m_pm[i] = hit;
            if (inc_e && select != SEL_NONE && int'(sel_alarm) == i)
                m_set[i] = bump(m_set[i], select);
        end
        m_inc_p = increment; m_snz_p = snooze; m_dis_p = dismiss;
        m_prev_sec = int'(sec_in);
    endtask

    task automatic compare_all();
        logic [N-1:0] exp_ring;
        int exp_id, sel;
        exp_ring = '0;
        exp_id = 0;
        for (int i = N - 1; i >= 0; i--) begin
            if (m_st[i] == 1) begin exp_ring[i] = 1'b1; exp_id = i; end
        end
        sel = int'(sel_alarm);
        check("ringing", ringing, exp_ring);
        check("out", out, |exp_ring);
        check("ring_id", ring_id, exp_id);
        check("sec_out", sec_out, m_set[sel] % 60);
        check("min_out", min_out, (m_set[sel] / 60) % 60);
        check("hour_out", hour_out, m_set[sel] / 3600);
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic set_time(input int t);
        now_s   = ((t % DAY) + DAY) % DAY;
        sec_in  = 6'(now_s % 60);
        min_in  = 6'((now_s / 60) % 60);
        hour_in = 5'(now_s / 3600);
    endtask

    task automatic pulse_inc(input int n);
        for (int k = 0; k < n; k++) begin
            increment = 1'b1; cycle();
            increment = 1'b0; cycle();
        end
    endtask

    initial begin
        int r, k;
        // Reset with every button held high: nothing must act on release.
        reset = 1'b0; increment = 1'b1; snooze = 1'b1; dismiss = 1'b1;
        arm = '0; select = SEL_SEC; sel_alarm = '0;
        set_time(0);
        model_reset();
        #1;
        check("rst_ringing", ringing, 0);
        check("rst_out", out, 0);
        check("rst_ring_id", ring_id, 0);
        compare_all();
        repeat (2) begin @(posedge clk); #1; compare_all(); end
        reset = 1'b1;
        repeat (3) cycle();
        increment = 1'b0; snooze = 1'b0; dismiss = 1'b0; select = SEL_NONE;
        cycle();

        // Edit wrap on channel 1 seconds.
        sel_alarm = 2'd1; select = SEL_SEC;
        pulse_inc(59);
        check("ch1_sec59", sec_out, 59);
        pulse_inc(1);
        check("ch1_sec_wrap", sec_out, 0);
        check("ch1_min_kept", min_out, 0);

        // Trigger channel 0 at 00:00:03.
        sel_alarm = 2'd0;
        pulse_inc(3);
        select = SEL_NONE; arm = 4'b0001;
        for (int s = 1; s <= 2; s++) begin set_time(s); repeat (4) cycle(); end
        set_time(3);
        cycle();
        check("trig_ringing", ringing, 4'b0001);
        check("trig_out", out, 1);
        check("trig_ch2_quiet", ringing[2], 0);

        // Dismiss while still in the matching second.
        dismiss = 1'b1; cycle();
        check("dismiss_drop", ringing, 0);
        dismiss = 1'b0;
        repeat (6) cycle();
        check("no_retrigger", ringing, 0);

        // Snooze: ring at 00:58:10, re-ring at 01:03:10.
        select = SEL_SEC; pulse_inc(7);
        select = SEL_MIN; pulse_inc(58);
        select = SEL_NONE;
        set_time(58 * 60 + 9); repeat (2) cycle();
        set_time(58 * 60 + 10); cycle();
        check("snz_first_ring", ringing[0], 1);
        snooze = 1'b1; cycle();
        check("snz_quiet", ringing[0], 0);
        snooze = 1'b0;
        repeat (3) cycle();
        set_time(3600 + 3 * 60 + 9); repeat (2) cycle();
        check("snz_not_yet", ringing[0], 0);
        set_time(3600 + 3 * 60 + 10); cycle();
        check("snz_rering", ringing[0], 1);

        // Timeout after RS seconds changes.
        repeat (RS - 1) begin set_time(now_s + 1); repeat (3) cycle(); end
        check("timeout_still", ringing[0], 1);
        set_time(now_s + 1); cycle();
        check("timeout_drop", ringing[0], 0);

        // Channels 0 and 3 ringing together.
        sel_alarm = 2'd3;
        select = SEL_SEC; pulse_inc(10);
        select = SEL_MIN; pulse_inc(58);
        select = SEL_NONE; arm = 4'b1001;
        set_time(58 * 60 + 9); repeat (2) cycle();
        set_time(58 * 60 + 10); cycle();
        check("both_ringing", ringing, 4'b1001);
        check("both_ring_id", ring_id, 0);
        arm = 4'b1000; cycle();
        check("arm_drop_ring_id", ring_id, 3);
        check("arm_drop_ringing", ringing, 4'b1000);
        #2 reset = 1'b0;
        #1;
        check("async_rst_ringing", ringing, 0);
        check("async_rst_out", out, 0);
        check("async_rst_ring_id", ring_id, 0);
        model_reset();
        @(posedge clk); #1; compare_all();
        reset = 1'b1;
        set_time(0);
        arm = 4'b1111;

        // Random phase against the model.
        for (int c = 0; c < 4000; c++) begin
            r = $urandom_range(0, 99);
            increment = ($urandom_range(0, 99) < 8);
            snooze    = ($urandom_range(0, 99) < 4);
            dismiss   = ($urandom_range(0, 99) < 2);
            if ($urandom_range(0, 99) < 3) arm = N'($urandom);
            sel_alarm = CW'($urandom_range(0, N - 1));
            select    = 2'($urandom_range(0, 3));
            if (r < 30) begin
                set_time(now_s + 1);
            end else if (r < 34) begin
                k = $urandom_range(0, N - 1);
                set_time(((m_st[k] == 2) ? m_snz[k] : m_set[k]) - 1);
            end
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alarm_bank.md
# alarm_bank

- Holds `N_ALARMS` independent alarm settings, each with its own arm control, and a per-alarm IDLE/RINGING/SNOOZED state machine.
- Adds snooze, dismiss and automatic ring timeout, which the single-alarm block does not have.
- Sits beside `Clock`: it takes `Clock`'s time outputs, is edited through the existing `select`/`increment` button scheme, and drives the buzzer and display logic.

## Interface
- `N_ALARMS`, 4: number of alarm channels (1..16).
- `RING_SECS`, 60: seconds an alarm rings before auto-stopping (1..255).
- `SNOOZE_MIN`, 5: snooze delay in minutes (1..59).
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  asynchronous, active-low; 0 resets all state.
- `sec_in`  in  6  current seconds from `Clock` (0..59).
- `min_in`  in  6  current minutes (0..59).
- `hour_in`  in  5  current hours (0..23).
- `sel_alarm`  in  CW  channel being edited and displayed; CW = max(1, clog2(N_ALARMS)).
- `select`  in  2  field select: `SELECT_NONE` / `SELECT_SEC` / `SELECT_MIN` / `SELECT_HOUR` (constants.vh).
- `increment`  in  1  edit button, level input; acts on its rising edge.
- `arm`  in  N_ALARMS  per-channel enable, level.
- `snooze`  in  1  snooze button; acts on its rising edge.
- `dismiss`  in  1  dismiss button; acts on its rising edge.
- `sec_out`, `min_out`, `hour_out`  out  6/6/5  stored setting of channel `sel_alarm` (combinational mux of registers).
- `ringing`  out  N_ALARMS  per-channel ringing flags, registered.
- `out`  out  1  OR of `ringing`, registered.
- `ring_id`  out  CW  lowest index with `ringing` set; 0 when none.

## Operation
- Per-channel registers: set time (sec, min, hour), snooze target (sec, min, hour), state, ring counter (8 bits), previous-match flag.
- Edit path:
  - Rising edge of `increment` with `select` ≠ `SELECT_NONE` increments the selected field of channel `sel_alarm`.
  - Sec and min wrap 59→0; hour wraps 23→0. There is no carry between fields.
  - A `sel_alarm` value ≥ N_ALARMS is ignored.
- Match:
  - `hit[i]` = current time equals the target, where the target is the set time in IDLE/RINGING and the snooze target in SNOOZED.
  - A channel triggers only on the rising edge of `hit[i]`. This stops a dismissed alarm from re-ringing within the same second.
- States:
  - IDLE → RINGING on a trigger while `arm[i]`=1. The ring counter loads `RING_SECS`.
  - RINGING → IDLE on a `dismiss` edge, or when the ring counter reaches 0.
  - The ring counter decrements on each cycle where `sec_in` differs from its value in the previous cycle.
  - RINGING → SNOOZED on a `snooze` edge. The snooze target is `sec_in`:`min_in`+`SNOOZE_MIN`. If the minutes reach ≥60, subtract 60 and increment the hour mod 24.
  - SNOOZED → RINGING on a snooze-target trigger; the counter reloads.
  - SNOOZED → IDLE on a `dismiss` edge.
  - Any state → IDLE when `arm[i]`=0.
- `snooze` and `dismiss` act on every channel currently in the relevant state.
- Priority per cycle: arm low > dismiss > snooze > timeout > trigger.
- Editing a channel's set time while it rings does not stop the ring. A new value can cause a trigger from the next cycle.

## Timing
- Reset values: all set times and snooze targets 00:00:00; states IDLE; `ringing`=0; `out`=0; `ring_id`=0; ring counters 0.
  - Previous-match flags reset to 1, so there is no trigger at reset release.
  - Button edge detectors reset to 1, so a button held through reset does not act.
- Edit latency: the field changes on the clock edge after the cycle in which `increment` is first sampled high. `sec_out` etc. reflect the change in the same cycle.
- Trigger latency: `ringing[i]` and `out` assert on the clock edge after the first cycle in which `hit[i]` is true.
- Button latency: `snooze` and `dismiss` take effect one edge after they are first sampled high. A held button acts once.
- Timeout: `ringing` drops on the edge that consumes the `RING_SECS`-th seconds change.
- Reset asserted mid-ring clears `ringing` and `out` immediately (asynchronously).

## Test plan
- Edit wrap: set channel 1 sec to 59 via 59 `increment` pulses, then pulse again. `sec_out`=0 and `min_out` is unchanged.
- Trigger: channel 0 set 00:00:03, `arm`=0001, `Clock` runs from reset. `ringing`=0001 and `out`=1 one cycle after `sec_in`=3. Channel 2 stays 0.
- Dismiss and no re-trigger: dismiss while time is still 00:00:03. `ringing` drops the next cycle and stays 0 for the rest of that second.
- Snooze: ring at 00:58:10, snooze. State is SNOOZED with target 01:03:10. Ringing re-asserts when the time reaches 01:03:10.
- Timeout: `RING_SECS`=3. `ringing` clears after the third `sec_in` change with no button pressed.
- Simultaneous events: channels 0 and 3 set to the same time. `ringing`=1001 and `ring_id`=0. Dropping `arm[0]` gives `ring_id`=3. Asserting reset mid-ring clears all outputs at once.
